// File: rtl/crtc_param.sv
// 6845-class CRT controller: character/raster/row timing, syncs, display enable, linear MA/RA, light pen, status.
// Optional cursor blink (R10[6:5] + frame counter) is built only when CRTC_CURSOR_BLINK_EN is defined.
module crtc_param #(
   parameter int HW  = 8,
   parameter int VW  = 7,
   parameter int RAW = 5,
   parameter int MAW = 14
) (
   input  logic           CLOCK,
   input  logic           nRESET,
   input  logic           CLKEN,
   input  logic           ENABLE,
   input  logic           nCS,
   input  logic           R_nW,
   input  logic           RS,
   input  logic [7:0]     DI,
   output logic [7:0]     DO,
   input  logic           LPSTB,
   output logic           HSYNC,
   output logic           VSYNC,
   output logic           DE,
   output logic           CURSOR,
   output logic [MAW-1:0] MA,
   output logic [RAW-1:0] RA
);
   localparam int HIW = MAW - 8;

   logic [4:0]     idx_q, idx_d;
   logic [HW-1:0]  r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
   logic [7:0]     r3_q, r3_d;
   logic [VW-1:0]  r4_q, r4_d, r6_q, r6_d, r7_q, r7_d;
   logic [RAW-1:0] r5_q, r5_d, r9_q, r9_d;
   logic [6:0]     r10_q, r10_d;
   logic [4:0]     r11_q, r11_d;
   logic [HIW-1:0] r12_q, r12_d, r14_q, r14_d, r16_q, r16_d;
   logic [7:0]     r13_q, r13_d, r15_q, r15_d, r17_q, r17_d;

   logic [HW-1:0]  hcc_q, hcc_d;
   logic [RAW-1:0] line_q, line_d;
   logic [VW-1:0]  row_q, row_d;
   logic           adjust_q, adjust_d;
   logic [MAW-1:0] row_base_q, row_base_d;
   logic           hs_q, hs_d, vs_q, vs_d;
   logic [3:0]     hs_cnt_q, hs_cnt_d, vs_cnt_q, vs_cnt_d;
   logic           cur_line_q, cur_line_d;
   logic [2:0]     lp_sync_q, lp_sync_d;
   logic           lpen_full_q, lpen_full_d;

   logic wr, rd17, lp_rise, hcc_last, line_last, hde, vde, vblank;
   logic cur_act, blink, new_frame, vs_start;

   assign wr        = ENABLE && !nCS && !R_nW;
   assign rd17      = ENABLE && !nCS && R_nW && RS && (idx_q == 5'd17);
   assign lp_rise   = lp_sync_q[1] && !lp_sync_q[2];
   assign hcc_last  = (hcc_q == r0_q);
   // During vertical adjust the raster counter runs 0..R5-1 instead of 0..R9.
   assign line_last = adjust_q ? (line_q == r5_q - 1'b1) : (line_q == r9_q);
   assign hde       = (hcc_q < r1_q);
   assign vde       = (row_q < r6_q) && !adjust_q;
   assign vblank    = !vde;
   assign DE        = hde && vde;
   assign MA        = row_base_q + MAW'(hcc_q);
   assign RA        = line_q;
   assign HSYNC     = hs_q;
   assign VSYNC     = vs_q;

   // Start line wins over end line; between them the last state is held.
   assign cur_act = (32'(line_q) == 32'(r10_q[4:0])) ? 1'b1 :
                    (32'(line_q) == 32'(r11_q))      ? 1'b0 : cur_line_q;
   assign CURSOR  = DE && cur_act && blink && (MA == {r14_q, r15_q});

`ifdef CRTC_CURSOR_BLINK_EN
   logic [4:0] frame_cnt_q, frame_cnt_d;
   always_comb begin
      frame_cnt_d = new_frame ? frame_cnt_q + 1'b1 : frame_cnt_q;
      case (r10_q[6:5])
         2'b00:   blink = 1'b1;
         2'b01:   blink = 1'b0;
         2'b10:   blink = !frame_cnt_q[3];
         default: blink = !frame_cnt_q[4];
      endcase
   end
   always_ff @(posedge CLOCK) begin
      if (!nRESET) frame_cnt_q <= '0;
      else         frame_cnt_q <= frame_cnt_d;
   end
`else
   assign blink = 1'b1;
`endif

   always_comb begin
      DO = 8'hFF;
      if (ENABLE && !nCS && R_nW) begin
         if (!RS) DO = {1'b0, lpen_full_q, vblank, 5'b0};
         else begin
            case (idx_q)
               5'd10:   DO = {1'b0, r10_q};
               5'd11:   DO = 8'(r11_q);
               5'd12:   DO = 8'(r12_q);
               5'd13:   DO = r13_q;
               5'd14:   DO = 8'(r14_q);
               5'd15:   DO = r15_q;
               5'd16:   DO = 8'(r16_q);
               5'd17:   DO = r17_q;
               default: DO = 8'h00;
            endcase
         end
      end
   end

   always_comb begin
      idx_d = idx_q; r0_d = r0_q; r1_d = r1_q; r2_d = r2_q; r3_d = r3_q; r4_d = r4_q;
      r5_d = r5_q; r6_d = r6_q; r7_d = r7_q; r9_d = r9_q; r10_d = r10_q; r11_d = r11_q;
      r12_d = r12_q; r13_d = r13_q; r14_d = r14_q; r15_d = r15_q; r16_d = r16_q; r17_d = r17_q;
      hcc_d = hcc_q; line_d = line_q; row_d = row_q; adjust_d = adjust_q; row_base_d = row_base_q;
      hs_d = hs_q; hs_cnt_d = hs_cnt_q; vs_d = vs_q; vs_cnt_d = vs_cnt_q; cur_line_d = cur_line_q;
      lpen_full_d = lpen_full_q;
      lp_sync_d   = {lp_sync_q[1:0], LPSTB};
      new_frame   = 1'b0;
      vs_start    = 1'b0;

      if (wr) begin
         if (!RS) idx_d = DI[4:0];
         else begin
            case (idx_q)
               5'd0:    r0_d  = HW'(DI);
               5'd1:    r1_d  = HW'(DI);
               5'd2:    r2_d  = HW'(DI);
               5'd3:    r3_d  = DI;
               5'd4:    r4_d  = VW'(DI);
               5'd5:    r5_d  = RAW'(DI);
               5'd6:    r6_d  = VW'(DI);
               5'd7:    r7_d  = VW'(DI);
               5'd9:    r9_d  = RAW'(DI);
               5'd10:   r10_d = DI[6:0];
               5'd11:   r11_d = DI[4:0];
               5'd12:   r12_d = DI[HIW-1:0];
               5'd13:   r13_d = DI;
               5'd14:   r14_d = DI[HIW-1:0];
               5'd15:   r15_d = DI;
               default: ;
            endcase
         end
      end

      if (CLKEN) begin
         hcc_d      = hcc_last ? '0 : hcc_q + 1'b1;
         cur_line_d = cur_act;
         if (hcc_last) begin
            if (adjust_q) begin
               if (line_last) new_frame = 1'b1;
               else           line_d    = line_q + 1'b1;
            end else if (line_last) begin
               row_base_d = row_base_q + MAW'(r1_q);
               line_d     = '0;
               if (row_q == r4_q) begin
                  if (r5_q != '0) adjust_d  = 1'b1;
                  else            new_frame = 1'b1;
               end else row_d = row_q + 1'b1;
            end else line_d = line_q + 1'b1;
            if (new_frame) begin
               row_d = '0; line_d = '0; adjust_d = 1'b0;
               row_base_d = {r12_q, r13_q};
            end
            vs_start = (line_d == '0) && !adjust_d && (row_d == r7_q) && (r7_q <= r4_q);
            // Sync counters stop on matching the programmed width; 4-bit wrap makes 0 mean 16.
            if (vs_q) begin
               if (vs_cnt_q == r3_q[7:4]) vs_d = 1'b0;
               else                        vs_cnt_d = vs_cnt_q + 1'b1;
            end else if (vs_start) begin
               vs_d = 1'b1; vs_cnt_d = 4'd1;
            end
         end
         if (hs_q) begin
            if (hs_cnt_q == r3_q[3:0]) hs_d = 1'b0;
            else                        hs_cnt_d = hs_cnt_q + 1'b1;
         end else if (hcc_q == r2_q) begin
            hs_d = 1'b1; hs_cnt_d = 4'd1;
         end
      end

      // A concurrent R17 read clears the flag and drops the strobe.
      if (rd17) lpen_full_d = 1'b0;
      else if (lp_rise && !lpen_full_q) begin
         lpen_full_d = 1'b1;
         r16_d = MA[MAW-1:8];
         r17_d = MA[7:0];
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!nRESET) begin
         idx_q <= '0; r0_q <= '0; r1_q <= '0; r2_q <= '0; r3_q <= '0; r4_q <= '0;
         r5_q <= '0; r6_q <= '0; r7_q <= '0; r9_q <= '0; r10_q <= '0; r11_q <= '0;
         r12_q <= '0; r13_q <= '0; r14_q <= '0; r15_q <= '0; r16_q <= '0; r17_q <= '0;
         hcc_q <= '0; line_q <= '0; row_q <= '0; adjust_q <= 1'b0; row_base_q <= '0;
         hs_q <= 1'b0; hs_cnt_q <= '0; vs_q <= 1'b0; vs_cnt_q <= '0; cur_line_q <= 1'b0;
         lp_sync_q <= '0; lpen_full_q <= 1'b0;
      end else begin
         idx_q <= idx_d; r0_q <= r0_d; r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d; r4_q <= r4_d;
         r5_q <= r5_d; r6_q <= r6_d; r7_q <= r7_d; r9_q <= r9_d; r10_q <= r10_d; r11_q <= r11_d;
         r12_q <= r12_d; r13_q <= r13_d; r14_q <= r14_d; r15_q <= r15_d; r16_q <= r16_d; r17_q <= r17_d;
         hcc_q <= hcc_d; line_q <= line_d; row_q <= row_d; adjust_q <= adjust_d; row_base_q <= row_base_d;
         hs_q <= hs_d; hs_cnt_q <= hs_cnt_d; vs_q <= vs_d; vs_cnt_q <= vs_cnt_d; cur_line_q <= cur_line_d;
         lp_sync_q <= lp_sync_d; lpen_full_q <= lpen_full_d;
      end
   end
endmodule

// File: tb/tb_crtc_param.sv
// Bench for crtc_param: directed stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_crtc_param;
   logic        CLOCK, nRESET, CLKEN, ENABLE, nCS, R_nW, RS, LPSTB;
   logic [7:0]  DI, DO;
   logic        HSYNC, VSYNC, DE, CURSOR;
   logic [13:0] MA;
   logic [4:0]  RA;

   crtc_param dut (
      .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN), .ENABLE(ENABLE), .nCS(nCS),
      .R_nW(R_nW), .RS(RS), .DI(DI), .DO(DO), .LPSTB(LPSTB), .HSYNC(HSYNC),
      .VSYNC(VSYNC), .DE(DE), .CURSOR(CURSOR), .MA(MA), .RA(RA)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic        sel;    // 0: video outputs, 1: DO
      logic [31:0] exp;
      logic [31:0] mask;
      string       name;
   } exp_t;

   localparam logic [31:0] M_ALL   = 32'h007F_FFFF;
   localparam logic [31:0] M_NOMA  = 32'h007F_C000;
   localparam logic [31:0] M_MA    = 32'h0000_3FFF;
   localparam logic [31:0] M_WRAP  = 32'h0017_FFFF;

   exp_t sb[$];
   logic chk_vld = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   always @(negedge CLOCK) begin : monitor
      exp_t        e;
      logic [31:0] act;
      if (chk_vld) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow: output presented with no expectation queued");
         end else begin
            e   = sb.pop_front();
            act = e.sel ? {24'h0, DO} : {9'b0, HSYNC, VSYNC, DE, CURSOR, RA, MA};
            if ((act & e.mask) !== (e.exp & e.mask)) begin
               n_bad++;
               $display("FAIL %s: got %h, required %h (mask %h)", e.name, act & e.mask, e.exp & e.mask, e.mask);
            end
         end
      end
   end

   function automatic logic [31:0] vid(input bit hs, input bit vs, input bit de, input bit cur,
                                       input int ra, input int ma);
      return {9'b0, hs, vs, de, cur, ra[4:0], ma[13:0]};
   endfunction

   // Test-plan timing (R0=7,R1=4,R2=5,R3=0x22,R4=2,R9=1,R6=2,R7=1, start 0x100, cursor 0x102 lines 0..0).
   function automatic logic [31:0] exp_basic(input int c, input bit adj);
      int flen, k, h, ln, row, l, ma;
      bit de, vs, cur, hs;
      flen = adj ? 72 : 48;
      k = c % flen; h = k % 8; ln = k / 8; hs = (h >= 6);
      if (ln < 6) begin
         row = ln / 2; l = ln % 2;
         ma  = ((c >= flen) ? 'h100 : 0) + row * 4 + h;
         de  = (h < 4) && (row < 2);
         vs  = (row == 1);
         cur = de && (l == 0) && (ma == 'h102);
      end else begin
         l = ln - 6; ma = 0; de = 1'b0; vs = 1'b0; cur = 1'b0;
      end
      return vid(hs, vs, de, cur, l, ma);
   endfunction

   task automatic tick();
      @(posedge CLOCK); #1;
      chk_vld = 1'b0;
   endtask

   task automatic push(input logic sel, input logic [31:0] v, input logic [31:0] m, input string nm);
      exp_t e;
      e.sel = sel; e.exp = v; e.mask = m; e.name = nm;
      sb.push_back(e);
      chk_vld = 1'b1;
   endtask

   task automatic expect_vid(input logic [31:0] v, input logic [31:0] m, input string nm);
      push(1'b0, v, m, nm);
      tick();
   endtask

   task automatic wr(input logic rs, input logic [7:0] d);
      ENABLE = 1'b1; nCS = 1'b0; R_nW = 1'b0; RS = rs; DI = d;
      tick();
      ENABLE = 1'b0; nCS = 1'b1; R_nW = 1'b1;
   endtask

   task automatic wreg(input int idx, input logic [7:0] d);
      wr(1'b0, 8'(idx));
      wr(1'b1, d);
   endtask

   task automatic rd(input logic rs, input logic [7:0] v, input string nm);
      ENABLE = 1'b1; nCS = 1'b0; R_nW = 1'b1; RS = rs;
      push(1'b1, {24'h0, v}, 32'hFF, nm);
      tick();
      ENABLE = 1'b0; nCS = 1'b1;
   endtask

   task automatic rreg(input int idx, input logic [7:0] v, input string nm);
      wr(1'b0, 8'(idx));
      rd(1'b1, v, nm);
   endtask

   task automatic do_reset();
      CLKEN = 1'b0; nRESET = 1'b0;
      tick(); tick();
      nRESET = 1'b1;
   endtask

   task automatic setup_basic(input logic [7:0] r5);
      wreg(0, 8'd7);  wreg(1, 8'd4);  wreg(2, 8'd5);  wreg(3, 8'h22);
      wreg(4, 8'd2);  wreg(5, r5);    wreg(6, 8'd2);  wreg(7, 8'd1);
      wreg(9, 8'd1);  wreg(10, 8'd0); wreg(11, 8'd1);
      wreg(12, 8'h01); wreg(13, 8'h00); wreg(14, 8'h01); wreg(15, 8'h02);
   endtask

   task automatic strobe();
      LPSTB = 1'b1; repeat (3) tick();
      LPSTB = 1'b0; repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nRESET = 1'b0; CLKEN = 1'b0; ENABLE = 1'b0; nCS = 1'b1; R_nW = 1'b1;
      RS = 1'b0; DI = 8'h00; LPSTB = 1'b0;
      tick();
      do_reset();
      expect_vid(32'h0, M_ALL, "reset_outputs");
      rd(1'b0, 8'h20, "status_reset");

      // Basic timing, cursor, then reset mid-frame with syncs active.
      setup_basic(8'd0);
      CLKEN = 1'b1;
      for (int c = 0; c < 70; c++) expect_vid(exp_basic(c, 1'b0), M_ALL, $sformatf("basic_c%0d", c));
      CLKEN = 1'b0;
      expect_vid(exp_basic(70, 1'b0), M_ALL, "basic_c70");
      expect_vid(exp_basic(70, 1'b0), M_ALL, "clken_low_hold");
      nRESET = 1'b0; tick(); nRESET = 1'b1;
      expect_vid(32'h0, M_ALL, "reset_midframe");
      rd(1'b0, 8'h20, "status_after_midframe_reset");

      // Vertical adjust of 3 lines.
      setup_basic(8'd3);
      CLKEN = 1'b1;
      for (int c = 0; c < 80; c++)
         expect_vid(exp_basic(c, 1'b1), (((c % 72) / 8) >= 6) ? M_NOMA : M_ALL, $sformatf("adjust_c%0d", c));

      // Sync width 0 means 16 characters / 16 lines.
      do_reset();
      wreg(0, 8'd19); wreg(1, 8'd4); wreg(2, 8'd2); wreg(3, 8'h00); wreg(4, 8'd1);
      wreg(6, 8'd1);  wreg(7, 8'd1); wreg(9, 8'd15); wreg(14, 8'h3F); wreg(15, 8'hFF);
      CLKEN = 1'b1;
      for (int c = 0; c < 660; c++) begin
         int k, h, ln, row;
         k = c % 640; h = k % 20; ln = k / 20; row = ln / 16;
         expect_vid(vid((h >= 3) && (h <= 18), ln >= 16, (h < 4) && (row < 1), 1'b0, ln % 16, row * 4 + h),
                    M_ALL, $sformatf("sync16_c%0d", c));
      end

      // MA wrap at 2^14; R12 high byte masked to 6 bits.
      do_reset();
      wreg(0, 8'd7); wreg(1, 8'd4); wreg(4, 8'd0); wreg(6, 8'd1); wreg(9, 8'd0);
      wreg(12, 8'hFF); wreg(13, 8'hFE);
      rreg(12, 8'h3F, "r12_masked");
      CLKEN = 1'b1;
      for (int c = 0; c < 24; c++)
         expect_vid(vid(1'b0, 1'b0, (c % 8) < 4, 1'b0, 0, (((c < 8) ? 0 : 'h3FFE) + c % 8) % 'h4000),
                    M_WRAP, $sformatf("mawrap_c%0d", c));
      CLKEN = 1'b0;

      // Light pen capture, hold, clear-on-read and recapture; register read map.
      do_reset();
      wreg(0, 8'd7); wreg(1, 8'd4); wreg(4, 8'd0); wreg(6, 8'd1); wreg(9, 8'd0);
      wreg(12, 8'h01); wreg(13, 8'h23);
      wreg(16, 8'h55);
      rreg(16, 8'h00, "r16_write_ignored");
      wreg(10, 8'h65);
      rreg(10, 8'h65, "r10_readback");
      rreg(1, 8'h00, "r1_reads_zero");
      push(1'b1, 32'hFF, 32'hFF, "do_not_selected");
      tick();
      CLKEN = 1'b1; repeat (8) tick(); CLKEN = 1'b0;
      expect_vid(32'h0123, M_MA, "ma_at_first_strobe");
      strobe();
      rd(1'b0, 8'h40, "status_lpen_full");
      rreg(16, 8'h01, "r16_capture");
      CLKEN = 1'b1; repeat (2) tick(); CLKEN = 1'b0;
      expect_vid(32'h0125, M_MA, "ma_at_second_strobe");
      strobe();
      rreg(16, 8'h01, "r16_hold");
      rreg(17, 8'h23, "r17_hold");
      rd(1'b0, 8'h00, "status_cleared_by_r17");
      strobe();
      rd(1'b0, 8'h40, "status_recapture");
      rreg(17, 8'h25, "r17_recapture");

      repeat (2) tick();
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
